// File: rtl/controller_pkg.sv
`default_nettype none
// ============================================================================
// Module : controller_pkg -- shared state encoding and defaults for the responder
// Rev    : 1.0
// ============================================================================
package controller_pkg;

    localparam int DEFAULT_NUM_BUTTONS = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/sync_edge.sv
`default_nettype none
// ============================================================================
// Module : sync_edge -- multi-flop synchronizer plus history flop, edge detect
// Rev    : 1.0
// ============================================================================
module sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] r_chain;
    logic                   r_hist;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_chain <= '0;
            r_hist  <= 1'b0;
        end else begin
            r_chain <= {r_chain[SYNC_STAGES-2:0], i_async};
            r_hist  <= r_chain[SYNC_STAGES-1];
        end
    end

    assign sync = r_chain[SYNC_STAGES-1];
    assign rise = sync & ~r_hist;
    assign fall = ~sync & r_hist;

endmodule
`default_nettype wire

// File: rtl/controller_responder.sv
`default_nettype none
// ============================================================================
// Module : controller_responder -- latch/pulse serial button responder
// Rev    : 1.0
// ============================================================================
module controller_responder
    import controller_pkg::*;
#(
    parameter int NUM_BUTTONS = DEFAULT_NUM_BUTTONS,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_BUTTONS-1:0] buttons,
    input  logic                   latch,
    input  logic                   pulse,
    output logic                   data,
    output logic                   busy,
    output logic [7:0]             frame_count
);

    localparam int                 c_IDX_W    = $clog2(NUM_BUTTONS + 1);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(NUM_BUTTONS - 1);

    logic w_latch_sync, w_latch_rise, w_latch_fall;
    logic w_pulse_sync, w_pulse_rise, w_pulse_fall;
    logic w_unused;

    state_t                 r_state;
    logic [NUM_BUTTONS-1:0] r_shreg;
    logic [c_IDX_W-1:0]     r_bit_index;
    logic [7:0]             r_frame_count;
    logic                   r_data;
    logic                   r_busy;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_latch_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (latch),
        .sync    (w_latch_sync),
        .rise    (w_latch_rise),
        .fall    (w_latch_fall)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_pulse_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (pulse),
        .sync    (w_pulse_sync),
        .rise    (w_pulse_rise),
        .fall    (w_pulse_fall)
    );

    assign w_unused = &{1'b0, w_latch_rise, w_pulse_sync, w_pulse_fall};

    // Outputs are registered from the current state, so data trails the
    // shift register by one clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_shreg       <= '1;
            r_bit_index   <= '0;
            r_frame_count <= '0;
            r_data        <= 1'b1;
            r_busy        <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (w_latch_sync) begin
                        r_state     <= LOAD;
                        r_shreg     <= ~buttons;
                        r_bit_index <= '0;
                    end
                end
                LOAD: begin
                    r_shreg     <= ~buttons;
                    r_bit_index <= '0;
                    if (w_latch_fall) begin
                        r_state       <= SHIFT;
                        r_frame_count <= r_frame_count + 8'd1;
                    end
                end
                SHIFT: begin
                    // A new latch aborts the frame and wins over a same-cycle pulse.
                    if (w_latch_sync) begin
                        r_state     <= LOAD;
                        r_shreg     <= ~buttons;
                        r_bit_index <= '0;
                    end else if (w_pulse_rise) begin
                        r_shreg     <= {1'b1, r_shreg[NUM_BUTTONS-1:1]};
                        r_bit_index <= r_bit_index + 1'b1;
                        if (r_bit_index == c_LAST_IDX) begin
                            r_state <= DONE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase

            r_busy <= (r_state == LOAD) || (r_state == SHIFT);
            r_data <= ((r_state == LOAD) || (r_state == SHIFT)) ? r_shreg[0] : 1'b1;
        end
    end

    assign data        = r_data;
    assign busy        = r_busy;
    assign frame_count = r_frame_count;

endmodule
`default_nettype wire
